// File: rtl/fixed_select_pkg.sv
// Shared types and constants for the fixed-predictor order selector.
package fixed_select_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int NUM_ORDERS = 5;

    // Wide enough that |-32768| = 32768 is representable.
    localparam int ABS_W = 17;

endpackage

// File: rtl/fixed_abs_accum.sv
// Absolute-value accumulator for one predictor order.
// Build option: FIXED_SELECT_SAT_EN makes the sum saturate at all-ones
// instead of wrapping.
module fixed_abs_accum
    import fixed_select_pkg::*;
#(
    parameter int SUM_W = 32
) (
    input  logic                    iClock,
    input  logic                    iReset_n,
    input  logic                    iClear,
    input  logic                    iEnable,
    input  logic signed [15:0]      iResidual,
    output logic [SUM_W-1:0]        oSum
);

    logic signed [ABS_W-1:0] res_ext;
    logic [ABS_W-1:0]        res_abs;
    logic [SUM_W:0]          sum_wide;
    logic [SUM_W-1:0]        sum_next;

    // Magnitude at 17 bits, then add with one carry bit of headroom.
    always_comb begin
        res_ext  = {iResidual[15], iResidual};
        res_abs  = res_ext[ABS_W-1] ? $unsigned(-res_ext) : $unsigned(res_ext);
        sum_wide = {1'b0, oSum} + (SUM_W+1)'(res_abs);
`ifdef FIXED_SELECT_SAT_EN
        sum_next = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
`else
        sum_next = sum_wide[SUM_W-1:0];
`endif
    end

    // Running sum register; clear has priority over accumulate.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oSum <= '0;
        end else if (iClear) begin
            oSum <= '0;
        end else if (iEnable) begin
            oSum <= sum_next;
        end
    end

endmodule

// File: rtl/fixed_order_selector.sv
// Sequences five fixed-predictor encoders over one block and reports the
// order with the smallest sum of |residual|.
// Build option: FIXED_SELECT_SAT_EN (saturating accumulators).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for iStart
// ST_CLR   | one cycle: reset encoders, clear sums and counters
// ST_FEED  | accepting samples; encoders enabled per accepted sample
// ST_FLUSH | LATENCY cycles of zero samples to drain encoder pipelines
// ST_CMP   | five cycles, compare order cmp_idx against the running best
// ST_DONE  | one-cycle oDone pulse with the result registered
module fixed_order_selector
    import fixed_select_pkg::*;
#(
    parameter int BLOCK_SIZE = 4096,
    parameter int LATENCY    = 8,
    parameter int WARMUP     = 4,
    parameter int SUM_W      = 32
) (
    input  logic                    iClock,
    input  logic                    iReset_n,
    input  logic                    iStart,
    input  logic                    iValid,
    input  logic signed [15:0]      iSample,
    output logic                    oReady,
    output logic                    oEncReset,
    output logic                    oEncEnable,
    output logic signed [15:0]      oEncSample,
    input  logic signed [15:0]      iResidual0,
    input  logic signed [15:0]      iResidual1,
    input  logic signed [15:0]      iResidual2,
    input  logic signed [15:0]      iResidual3,
    input  logic signed [15:0]      iResidual4,
    output logic [2:0]              oBestOrder,
    output logic [SUM_W-1:0]        oBestSum,
    output logic                    oDone,
    output logic                    oBusy
);

    localparam int S_W = $clog2(BLOCK_SIZE + 1);
    localparam int E_W = $clog2(BLOCK_SIZE + LATENCY + 1);
    localparam int F_W = $clog2(LATENCY + 1);

    state_t state, state_nxt;

    logic [S_W-1:0]          s_cnt;
    logic [E_W-1:0]          e_cnt;
    logic [F_W-1:0]          flush_cnt;
    logic [2:0]              cmp_idx;
    logic [2:0]              best_order;
    logic [SUM_W-1:0]        best_sum;
    logic [SUM_W-1:0]        cmp_sum;
    logic                    cmp_take;
    logic                    accept;
    logic                    last_accept;
    logic                    acc_en;
    logic signed [15:0]      residual [NUM_ORDERS];
    logic [SUM_W-1:0]        acc_sum  [NUM_ORDERS];

    assign residual[0] = iResidual0;
    assign residual[1] = iResidual1;
    assign residual[2] = iResidual2;
    assign residual[3] = iResidual3;
    assign residual[4] = iResidual4;

    assign accept      = (state == ST_FEED) && iValid;
    assign last_accept = accept && (s_cnt == S_W'(BLOCK_SIZE - 1));

    // e_cnt is the enable count before this cycle's increment; the residual
    // on the inputs belongs to sample j = e_cnt - LATENCY.
    assign acc_en = oEncEnable
                 && (e_cnt >= E_W'(LATENCY + WARMUP))
                 && (e_cnt <  E_W'(LATENCY + BLOCK_SIZE));

    // State register.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and encoder-side outputs.
    always_comb begin
        state_nxt  = state;
        oReady     = 1'b0;
        oEncReset  = 1'b0;
        oEncEnable = 1'b0;
        oEncSample = '0;
        oDone      = 1'b0;
        oBusy      = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (iStart) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                oEncReset = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED: begin
                oReady     = 1'b1;
                oEncEnable = iValid;
                oEncSample = iSample;
                if (last_accept) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                oEncEnable = 1'b1;
                if (flush_cnt == '0) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                if (cmp_idx == 3'(NUM_ORDERS - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                oDone     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sample counter, enable counter and flush down-counter.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            s_cnt     <= '0;
            e_cnt     <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_CLR: begin
                    s_cnt <= '0;
                    e_cnt <= '0;
                end
                ST_FEED: begin
                    if (accept) begin
                        s_cnt     <= s_cnt + 1'b1;
                        e_cnt     <= e_cnt + 1'b1;
                        flush_cnt <= F_W'(LATENCY - 1);
                    end
                end
                ST_FLUSH: begin
                    e_cnt     <= e_cnt + 1'b1;
                    flush_cnt <= flush_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Select the sum under comparison; strictly-less keeps ties on the lower order.
    always_comb begin
        cmp_sum = acc_sum[0];
        for (int k = 1; k < NUM_ORDERS; k++) begin
            if (cmp_idx == 3'(k)) cmp_sum = acc_sum[k];
        end
        cmp_take = (cmp_idx == 3'd0) || (cmp_sum < best_sum);
    end

    // Running best and the registered result, published on entry to ST_DONE.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            cmp_idx    <= '0;
            best_order <= '0;
            best_sum   <= '0;
            oBestOrder <= '0;
            oBestSum   <= '0;
        end else if (state == ST_CMP) begin
            cmp_idx <= cmp_idx + 1'b1;
            if (cmp_take) begin
                best_order <= cmp_idx;
                best_sum   <= cmp_sum;
            end
            if (cmp_idx == 3'(NUM_ORDERS - 1)) begin
                oBestOrder <= cmp_take ? cmp_idx : best_order;
                oBestSum   <= cmp_take ? cmp_sum : best_sum;
            end
        end else begin
            cmp_idx <= '0;
        end
    end

    for (genvar k = 0; k < NUM_ORDERS; k++) begin : g_accum
        fixed_abs_accum #(
            .SUM_W (SUM_W)
        ) u_accum (
            .iClock    (iClock),
            .iReset_n  (iReset_n),
            .iClear    (oEncReset),
            .iEnable   (acc_en),
            .iResidual (residual[k]),
            .oSum      (acc_sum[k])
        );
    end

endmodule

// File: tb/tb_fixed_order_selector.sv
// Self-checking bench for fixed_order_selector with behavioural encoders.
// Honours FIXED_SELECT_SAT_EN in its reference model.
module tb_fixed_order_selector;

    localparam int BS  = 16;
    localparam int LAT = 8;
    localparam int WU  = 4;
    localparam int SW  = 16;

    logic               iClock;
    logic               iReset_n;
    logic               iStart;
    logic               iValid;
    logic signed [15:0] iSample;
    logic               oReady;
    logic               oEncReset;
    logic               oEncEnable;
    logic signed [15:0] oEncSample;
    logic signed [15:0] res_out [0:4];
    logic [2:0]         oBestOrder;
    logic [SW-1:0]      oBestSum;
    logic               oDone;
    logic               oBusy;

    int n_checks = 0;
    int n_fail   = 0;
    int samp [0:BS-1];
    int exp_order, exp_sum;
    int clr_cnt = 0, done_cnt = 0, en_cnt = 0, en_viol = 0, samp_viol = 0;

    fixed_order_selector #(
        .BLOCK_SIZE (BS),
        .LATENCY    (LAT),
        .WARMUP     (WU),
        .SUM_W      (SW)
    ) dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iStart     (iStart),
        .iValid     (iValid),
        .iSample    (iSample),
        .oReady     (oReady),
        .oEncReset  (oEncReset),
        .oEncEnable (oEncEnable),
        .oEncSample (oEncSample),
        .iResidual0 (res_out[0]),
        .iResidual1 (res_out[1]),
        .iResidual2 (res_out[2]),
        .iResidual3 (res_out[3]),
        .iResidual4 (res_out[4]),
        .oBestOrder (oBestOrder),
        .oBestSum   (oBestSum),
        .oDone      (oDone),
        .oBusy      (oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    function automatic int pred_res(input int k, input int x0, input int x1,
                                    input int x2, input int x3, input int x4);
        case (k)
            0:       return x0;
            1:       return x0 - x1;
            2:       return x0 - 2*x1 + x2;
            3:       return x0 - 3*x1 + 3*x2 - x3;
            default: return x0 - 4*x1 + 6*x2 - 4*x3 + x4;
        endcase
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Behavioural encoders: LAT-deep pipeline advancing only on enable.
    int hist [0:3];
    logic signed [15:0] pipe [0:4][0:LAT-1];

    always @(posedge iClock) begin
        if (oEncReset) begin
            for (int k = 0; k < 5; k++)
                for (int d = 0; d < LAT; d++) pipe[k][d] <= '0;
            for (int h = 0; h < 4; h++) hist[h] <= 0;
        end else if (oEncEnable) begin
            for (int k = 0; k < 5; k++) begin
                pipe[k][0] <= 16'(clamp16(pred_res(k, int'(oEncSample),
                                    hist[0], hist[1], hist[2], hist[3])));
                for (int d = 1; d < LAT; d++) pipe[k][d] <= pipe[k][d-1];
            end
            hist[0] <= int'(oEncSample);
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) res_out[k] = pipe[k][LAT-1];
    end

    // Interface monitors, sampled after the stimulus settles.
    always @(negedge iClock) begin
        #4;
        if (oDone) done_cnt++;
        if (iReset_n) begin
            if (oEncReset)  clr_cnt++;
            if (oEncEnable) en_cnt++;
            if (oReady && (oEncEnable != iValid)) en_viol++;
            if (!oReady && (oEncSample != 16'sd0)) samp_viol++;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Per-order sums straight from the sample list, then cheapest order.
    task automatic ref_model();
        int sums [0:4];
        int r, a;
        int max_v = (1 << SW) - 1;
        for (int k = 0; k < 5; k++) begin
            sums[k] = 0;
            for (int j = WU; j < BS; j++) begin
                r = clamp16(pred_res(k, samp[j], samp[j-1], samp[j-2], samp[j-3], samp[j-4]));
                a = (r < 0) ? -r : r;
`ifdef FIXED_SELECT_SAT_EN
                sums[k] = (sums[k] + a > max_v) ? max_v : sums[k] + a;
`else
                sums[k] = (sums[k] + a) & max_v;
`endif
            end
        end
        exp_order = 0;
        exp_sum   = sums[0];
        for (int k = 1; k < 5; k++) begin
            if (sums[k] < exp_sum) begin
                exp_order = k;
                exp_sum   = sums[k];
            end
        end
    endtask

    // mode: 0 continuous, 1 valid toggling, 2 random gaps.
    task automatic run_block(input int mode, input bit hold_start,
                             input bit skip_start, input int rst_at);
        int idx, cyc, lat, clr0, en0, d0;
        bit v;
        ref_model();
        clr0 = clr_cnt;
        en0  = en_cnt;
        if (!skip_start) begin
            @(negedge iClock);
            #1 iStart = 1'b1;
        end
        idx = 0;
        cyc = 0;
        while (idx < BS && cyc < 4*BS + 20) begin
            @(negedge iClock);
            cyc++;
            if (rst_at >= 0 && idx == rst_at && oReady) begin
                d0 = done_cnt;
                #1 iReset_n = 1'b0;
                iValid = 1'b1;
                #1;
                chk_val("rst_busy",    oBusy,      0);
                chk_val("rst_ready",   oReady,     0);
                chk_val("rst_enable",  oEncEnable, 0);
                chk_val("rst_sample",  oEncSample, 0);
                chk_val("rst_order",   oBestOrder, 0);
                chk_val("rst_sum",     oBestSum,   0);
                iValid = 1'b0;
                repeat (3) @(negedge iClock);
                #1 iReset_n = 1'b1;
                iStart = 1'b0;
                repeat (20) @(negedge iClock);
                chk_val("rst_no_done", done_cnt - d0, 0);
                return;
            end
            v = oReady && (mode == 0 || (mode == 1 && cyc[0]) ||
                           (mode == 2 && $urandom_range(0, 3) != 0));
            #1;
            iStart  = hold_start;
            iValid  = v;
            iSample = v ? 16'(samp[idx]) : 16'($urandom);
            if (v) idx++;
        end
        if (idx < BS) begin
            chk_val("feed_timeout", idx, BS);
            return;
        end
        lat = 0;
        while (lat < 40) begin
            @(negedge iClock);
            lat++;
            if (oDone) break;
            #1;
            iValid = 1'b0;
            iStart = hold_start;
        end
        chk_val("done_latency", lat, LAT + 6);
        chk_val("best_order",   oBestOrder, exp_order);
        chk_val("best_sum",     oBestSum,   exp_sum);
        chk_val("clr_per_block", clr_cnt - clr0, 1);
        chk_val("enables",      en_cnt - en0, BS + LAT);
        @(negedge iClock);
        chk_val("idle_after_done", oBusy, 0);
        chk_val("held_sum",        oBestSum, exp_sum);
        if (hold_start) begin
            @(negedge iClock);
            chk_val("clr_after_done", oEncReset, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] t;
        iReset_n = 1'b0;
        iStart   = 1'b0;
        iValid   = 1'b0;
        iSample  = '0;
        repeat (3) @(negedge iClock);
        chk_val("reset_busy",  oBusy,      0);
        chk_val("reset_done",  oDone,      0);
        chk_val("reset_ready", oReady,     0);
        chk_val("reset_encrst", oEncReset, 0);
        chk_val("reset_order", oBestOrder, 0);
        chk_val("reset_sum",   oBestSum,   0);
        #1 iReset_n = 1'b1;

        for (int j = 0; j < BS; j++) samp[j] = 100;
        run_block(0, 1'b0, 1'b0, -1);
        for (int j = 0; j < BS; j++) samp[j] = 3 * j;
        run_block(0, 1'b0, 1'b0, -1);
        for (int j = 0; j < BS; j++) samp[j] = j * j;
        run_block(1, 1'b0, 1'b0, -1);
        for (int j = 0; j < BS; j++) samp[j] = (j % 2 == 0) ? 32767 : -32768;
        run_block(0, 1'b0, 1'b0, -1);

        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < BS; j++) begin
                if (b < 3) begin
                    samp[j] = int'($urandom_range(0, 400)) - 200;
                end else begin
                    t = 16'($urandom);
                    samp[j] = int'(t);
                end
            end
            run_block(2, 1'b0, 1'b0, -1);
        end

        for (int j = 0; j < BS; j++) samp[j] = 3 * j;
        run_block(0, 1'b0, 1'b0, -1);
        run_block(0, 1'b0, 1'b0, 7);
        for (int j = 0; j < BS; j++) samp[j] = int'($urandom_range(0, 2000)) - 1000;
        run_block(2, 1'b0, 1'b0, -1);

        for (int j = 0; j < BS; j++) samp[j] = j * j;
        run_block(0, 1'b1, 1'b0, -1);
        for (int j = 0; j < BS; j++) samp[j] = 100;
        run_block(0, 1'b0, 1'b1, -1);

        repeat (2) @(negedge iClock);
        chk_val("enable_follows_valid", en_viol,   0);
        chk_val("enc_sample_zero",      samp_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_order_selector.md
Name: fixed_order_selector

Overview:
- Sequences the five fixed-predictor encoders (orders 0-4) over one block of audio samples.
- Feeds them a common sample stream and drives their enable and reset.
- Flushes their pipelines and accumulates the sum of |residual| per order.
- Reports the cheapest order to the downstream FLAC frame builder.

Parameters:
- BLOCK_SIZE, 4096, samples per block; legal range 5..65535.
- LATENCY, 8, encoder enables from sample in to residual out; identical for all orders.
- WARMUP, 4, leading samples excluded from every sum (max predictor order).
- SUM_W, 32, accumulator width.

Ports:
- iClock  in  1  clock
- iReset_n  in  1  asynchronous active-low reset
- iStart  in  1  begin a new block; honoured only in IDLE
- iValid  in  1  iSample valid; consumed only in FEED
- iSample  in  16  signed sample
- oReady  out  1  high in FEED (sample accepted when iValid&oReady)
- oEncReset  out  1  synchronous active-high reset to all encoders
- oEncEnable  out  1  enable to all encoders
- oEncSample  out  16  sample to all encoders
- iResidual0..iResidual4  in  16 each  signed encoder outputs
- oBestOrder  out  3  winning order 0..4
- oBestSum  out  SUM_W  winning sum
- oDone  out  1  one-cycle pulse; oBestOrder/oBestSum valid and held until next oDone
- oBusy  out  1  state != IDLE

Behaviour:
- Reset (async, iReset_n=0): state IDLE; all outputs 0; counters and sums 0.
- States and transitions:
  - IDLE -> CLR on iStart.
  - CLR: 1 cycle; oEncReset=1; clears sums, sample counter s and enable counter e. -> FEED.
  - FEED: oReady=1; oEncEnable=iValid; oEncSample=iSample. On each accepted sample, s++ and e++. After the accept where s reaches BLOCK_SIZE -> FLUSH. Gaps in iValid stall everything.
  - FLUSH: exactly LATENCY cycles; oEncEnable=1; oEncSample=0; e++ each cycle. -> CMP.
  - CMP: 5 cycles, one order per cycle (0..4) vs running best. Strictly-less replaces the best, so ties go to the lowest order. -> DONE.
  - DONE: oDone=1 for 1 cycle; outputs latch. -> IDLE.
- Accumulation:
  - Happens in any cycle with oEncEnable=1 and e>=LATENCY (e = value before the increment).
  - Residual index j = e-LATENCY.
  - Add only when WARMUP <= j < BLOCK_SIZE.
  - |x| is computed at 17 bits so -32768 gives 32768, then zero-extended to SUM_W.
  - Without the optional feature the sum wraps modulo 2^SUM_W.
- Simultaneous events: iStart outside IDLE is ignored. iValid outside FEED is ignored. iStart in the same cycle as DONE is ignored; it is taken the next cycle.
- oEncSample=0 whenever not in FEED.
- Reset mid-block: immediate return to IDLE. Previous oBestOrder/oBestSum are cleared to 0. The encoders are re-cleared by CLR on the next iStart.
- Minimum block latency from the last accepted sample to oDone: LATENCY + 5 + 1 cycles.

Optional Feature:
- Macro FIXED_SELECT_SAT_EN.
- Defined: each accumulator saturates at 2^SUM_W-1 and a saturated sum stays there.
- Undefined: wrap-around arithmetic.
- Both builds give identical results when no overflow occurs.

Decomposition:
- Package fixed_select_pkg holds:
  - state encoding (IDLE, CLR, FEED, FLUSH, CMP, DONE);
  - NUM_ORDERS=5;
  - abs-value width constant ABS_W=17.
- One natural sub-module, fixed_abs_accum: 17-bit abs plus SUM_W accumulate with clear, enable and optional saturation. It is instantiated 5 times.
- The FSM, counters and comparator stay in the top level.

Test Plan:
- Constant input 100, BLOCK_SIZE=16, behavioural order-0..4 encoder models -> sums {1200,0,0,0,0}; oBestOrder=1, oBestSum=0; oDone 14 cycles after the last accept.
- Ramp s[n]=3n -> order0 sum=3*(4+..+15)=342, order1 sum=36, orders 2-4 sum=0; oBestOrder=2.
- Quadratic s[n]=n*n, iValid toggled 1-0-1 every cycle -> oBestOrder=3, sum 0; oEncEnable never high while iValid=0 in FEED.
- Alternating +32767/-32768, SUM_W=16:
  - FIXED_SELECT_SAT_EN defined -> all five sums read 16'hFFFF and oBestOrder=0.
  - Macro undefined -> values match the modulo-65536 reference model.
- iReset_n pulsed low mid-FEED at sample 7 -> all outputs 0 in the same cycle, oDone never pulses; next iStart block completes correctly.
- iStart held high through a whole block -> exactly one CLR per block; a new block starts the cycle after DONE.
